// File: rtl/load_store_unit.sv
// Load/store unit between execute and a variable-latency data memory.
// Generates byte strobes, shifts lanes, extends loads and detects or splits misaligned accesses.
module load_store_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_WIDTH       = 12,
  parameter bit ALLOW_MISALIGNED = 1'b0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_store,
  input  logic [1:0]                       req_size,
  input  logic                             req_signed,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [XLEN-1:0]                  req_wdata,
  output logic                             rsp_valid,
  output logic [XLEN-1:0]                  rsp_rdata,
  output logic                             rsp_err,
  output logic                             mem_req,
  input  logic                             mem_gnt,
  output logic [ADDR_WIDTH-$clog2(XLEN/8)-1:0] mem_addr,
  output logic [XLEN/8-1:0]                mem_we,
  output logic [XLEN-1:0]                  mem_wdata,
  input  logic                             mem_rvalid,
  input  logic [XLEN-1:0]                  mem_rdata,
  output logic [1:0]                       dbg_state_o
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int MW = ADDR_WIDTH - OW;

  // Handshakes: a request transfers on a clock edge where req_valid && req_ready;
  // a memory beat transfers on an edge where mem_req && mem_gnt; read data arrives
  // on an edge with mem_rvalid while waiting; rsp_valid is a single-cycle pulse.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_R, S_RESP} state_e;

  state_e                state_q, state_d;
  logic                  store_q, store_d;
  logic                  signed_q, signed_d;
  logic                  split_q, split_d;
  logic                  beat_q, beat_d;
  logic                  err_q, err_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;

  logic [OW-1:0]   req_off;
  logic [3:0]      req_bytes;
  logic            req_illegal, req_misal, req_split, req_err;
  logic            last_beat;

  assign req_off     = req_addr[OW-1:0];
  assign req_bytes   = 4'd1 << req_size;
  assign req_illegal = (req_size == 2'd3) && (XLEN == 32);
  assign req_misal   = (req_off & OW'(req_bytes - 4'd1)) != '0;
  assign req_split   = (int'(req_off) + int'(req_bytes)) > NB;
  assign req_err     = req_illegal || (req_misal && !ALLOW_MISALIGNED);
  assign last_beat   = !split_q || beat_q;

  logic [OW-1:0]     off_q;
  logic [OW+3:0]     sh_lo, sh_hi;
  logic [NB-1:0]     bm;
  logic [2*NB-1:0]   we_full;
  logic [2*XLEN-1:0] wd_full;
  logic [XLEN-1:0]   ext_mask;
  logic              sign_bit;

  assign off_q    = addr_q[OW-1:0];
  assign sh_lo    = {1'b0, off_q, 3'b000};
  assign sh_hi    = (OW+4)'(8 * NB) - sh_lo;
  assign bm       = ~({NB{1'b1}} << (32'd1 << size_q));
  assign we_full  = {{NB{1'b0}}, bm} << off_q;
  assign wd_full  = {{XLEN{1'b0}}, wdata_q} << sh_lo;
  assign ext_mask = ~({XLEN{1'b1}} << (32'd8 << size_q));

  always_comb begin
    case (size_q)
      2'd0:    sign_bit = rdata_q[7];
      2'd1:    sign_bit = rdata_q[15];
      2'd2:    sign_bit = rdata_q[31];
      default: sign_bit = rdata_q[XLEN-1];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          beat_d  = 1'b0;
          state_d = req_err ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_gnt) begin
          if (!store_q) begin
            state_d = S_WAIT_R;
          end else if (last_beat) begin
            state_d = S_RESP;
          end else begin
            beat_d = 1'b1;
          end
        end
      end
      S_WAIT_R: begin
        if (mem_rvalid) begin
          if (last_beat) begin
            state_d = S_RESP;
          end else begin
            beat_d  = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    store_d  = store_q;
    signed_d = signed_q;
    split_d  = split_q;
    err_d    = err_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    if (state_q == S_IDLE && req_valid) begin
      store_d  = req_store;
      signed_d = req_signed;
      split_d  = req_split;
      err_d    = req_err;
      size_d   = req_size;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
      rdata_d  = '0;
    end
    // Beat 0 fills the low bytes, beat 1 ORs the wrapped bytes on top.
    if (state_q == S_WAIT_R && mem_rvalid) begin
      rdata_d = beat_q ? (rdata_q | (mem_rdata << sh_hi)) : (mem_rdata >> sh_lo);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      store_q  <= 1'b0;
      signed_q <= 1'b0;
      split_q  <= 1'b0;
      beat_q   <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      store_q  <= store_d;
      signed_q <= signed_d;
      split_q  <= split_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    req_ready   = (state_q == S_IDLE);
    mem_req     = (state_q == S_ISSUE);
    mem_addr    = '0;
    mem_we      = '0;
    mem_wdata   = '0;
    rsp_valid   = (state_q == S_RESP);
    rsp_err     = (state_q == S_RESP) && err_q;
    rsp_rdata   = '0;
    dbg_state_o = state_q;
    if (state_q == S_ISSUE) begin
      mem_addr  = beat_q ? addr_q[ADDR_WIDTH-1:OW] + MW'(1) : addr_q[ADDR_WIDTH-1:OW];
      mem_wdata = beat_q ? wd_full[2*XLEN-1:XLEN] : wd_full[XLEN-1:0];
      if (store_q) begin
        mem_we = beat_q ? we_full[2*NB-1:NB] : we_full[NB-1:0];
      end
    end
    if (state_q == S_RESP && !err_q && !store_q) begin
      rsp_rdata = (rdata_q & ext_mask) | ({XLEN{signed_q & sign_bit}} & ~ext_mask);
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit (XLEN=32): a splitting instance and an erroring instance,
// a byte-lane reference memory model and expected-beat/response queues.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_valid_e;
  logic        req_store, req_signed;
  logic [1:0]  req_size;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        req_ready, rsp_valid, rsp_err, mem_req;
  logic [31:0] rsp_rdata, mem_wdata;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_we;
  logic [1:0]  dbg_state;
  logic        req_ready_e, rsp_valid_e, rsp_err_e, mem_req_e;
  logic [31:0] rsp_rdata_e, mem_wdata_e;
  logic [9:0]  mem_addr_e;
  logic [3:0]  mem_we_e;
  logic [1:0]  dbg_state_e;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] phys_mem [0:1023];
  logic [31:0] ref_mem  [0:1023];

  logic [9:0]  exp_addr_q[$], obs_addr_q[$];
  logic [3:0]  exp_we_q[$],   obs_we_q[$];
  logic [31:0] exp_wd_q[$],   obs_wd_q[$];
  logic [0:0]  exp_st_q[$];
  logic [32:0] exp_q[$],      obs_q[$];
  int          exp_lat_q[$],  obs_lat_q[$];

  load_store_unit #(.XLEN(32), .ADDR_WIDTH(12), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
  );

  load_store_unit #(.XLEN(32), .ADDR_WIDTH(12), .ALLOW_MISALIGNED(1'b0)) u_dut_e (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_e), .req_ready(req_ready_e),
    .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_e),
    .rsp_rdata(rsp_rdata_e), .rsp_err(rsp_err_e), .mem_req(mem_req_e), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr_e), .mem_we(mem_we_e), .mem_wdata(mem_wdata_e),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state_e)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_push(input logic st, input logic [1:0] sz, input logic sg,
                            input logic [11:0] ad, input logic [31:0] wd,
                            input int gw, input int rw, input bit allow);
    int          bytes, nb, off;
    logic [11:0] a;
    logic [9:0]  w0;
    logic [3:0]  we0, we1;
    logic [31:0] val;
    bytes = 1 << sz;
    off   = int'(ad[1:0]);
    if (sz == 2'd3 || (!allow && (int'(ad) % bytes) != 0)) begin
      exp_q.push_back({1'b1, 32'h0});
      exp_lat_q.push_back(1);
      return;
    end
    w0 = ad[11:2]; nb = 1; we0 = 4'b0; we1 = 4'b0; val = 32'h0;
    for (int i = 0; i < bytes; i++) begin
      a = ad + 12'(i);
      if (a[11:2] != w0) begin
        nb = 2;
        we1[a[1:0]] = 1'b1;
      end else begin
        we0[a[1:0]] = 1'b1;
      end
      if (st) ref_mem[a[11:2]][8*a[1:0] +: 8] = wd[8*i +: 8];
      else    val[8*i +: 8] = ref_mem[a[11:2]][8*a[1:0] +: 8];
    end
    if (!st && sg && bytes < 4 && val[8*bytes-1]) val = val | (32'hFFFF_FFFF << (8*bytes));
    for (int k = 0; k <= gw; k++) begin
      exp_addr_q.push_back(w0);
      exp_we_q.push_back(st ? we0 : 4'b0);
      exp_wd_q.push_back(wd << (8*off));
      exp_st_q.push_back(st);
    end
    if (nb == 2) begin
      for (int k = 0; k <= gw; k++) begin
        exp_addr_q.push_back(w0 + 10'd1);
        exp_we_q.push_back(st ? we1 : 4'b0);
        exp_wd_q.push_back(wd >> (8*(4-off)));
        exp_st_q.push_back(st);
      end
    end
    exp_q.push_back({1'b0, st ? 32'h0 : val});
    exp_lat_q.push_back(1 + nb * (st ? gw + 1 : gw + rw + 2));
  endtask

  // ---------------- driver / memory responder (records observations) ----------------
  task automatic drive_access(input logic st, input logic [1:0] sz, input logic sg,
                              input logic [11:0] ad, input logic [31:0] wd,
                              input int gw, input int rw);
    int         cyc, waits, rwaits;
    bit         done, rd_pend;
    logic [9:0] rd_word;
    for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; waits = 0; rwaits = 0; done = 1'b0; rd_pend = 1'b0; rd_word = 10'h0;
    while (!done && cyc < 60) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (rsp_valid) begin
        obs_q.push_back({rsp_err, rsp_rdata});
        obs_lat_q.push_back(cyc);
        done = 1'b1;
      end else if (mem_req) begin
        obs_addr_q.push_back(mem_addr);
        obs_we_q.push_back(mem_we);
        obs_wd_q.push_back(mem_wdata);
        if (waits == gw) begin
          mem_gnt = 1'b1; waits = 0;
          if (!st) begin
            rd_pend = 1'b1; rwaits = 0; rd_word = mem_addr;
          end else begin
            for (int j = 0; j < 4; j++)
              if (mem_we[j]) phys_mem[mem_addr][8*j +: 8] = mem_wdata[8*j +: 8];
          end
        end else begin
          waits++;
        end
      end else if (rd_pend) begin
        if (rwaits == rw) begin
          mem_rvalid = 1'b1; mem_rdata = phys_mem[rd_word]; rd_pend = 1'b0;
        end else begin
          rwaits++;
        end
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (!done) begin
      obs_q.push_back('x);
      obs_lat_q.push_back(-1);
    end
  endtask

  task automatic clear_queues();
    exp_addr_q.delete(); exp_we_q.delete(); exp_wd_q.delete(); exp_st_q.delete();
    obs_addr_q.delete(); obs_we_q.delete(); obs_wd_q.delete();
    exp_q.delete(); obs_q.delete(); exp_lat_q.delete(); obs_lat_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [83:0] exp_v;
    exp_v = {1'b1, 83'h0};
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({req_ready, mem_req, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_err, rsp_rdata, dbg_state} !== exp_v) begin
      n_err++;
      $display("FAIL reset_in: got rdy=%b req=%b we=%b addr=%h wd=%h v=%b e=%b rd=%h st=%0d want rdy=1 rest 0",
               req_ready, mem_req, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_err, rsp_rdata, dbg_state);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({req_ready_e, mem_req_e, mem_we_e, mem_addr_e, mem_wdata_e, rsp_valid_e, rsp_err_e, rsp_rdata_e, dbg_state_e} !== exp_v) begin
      n_err++;
      $display("FAIL reset_out_e: got rdy=%b req=%b we=%b addr=%h wd=%h v=%b e=%b rd=%h st=%0d want rdy=1 rest 0",
               req_ready_e, mem_req_e, mem_we_e, mem_addr_e, mem_wdata_e, rsp_valid_e, rsp_err_e, rsp_rdata_e, dbg_state_e);
    end
  endtask

  task automatic test_aligned();
    logic [9:0] oa, ea; logic [3:0] ow, ew; logic [31:0] od, ed; logic [0:0] es;
    logic [32:0] orsp, ersp; int ol, el;
    phys_mem[0] = 32'h8001_1234; ref_mem[0] = 32'h8001_1234;
    model_push(1'b1, 2'd0, 1'b0, 12'h006, 32'h0000_00A5, 0, 0, 1'b1);
    drive_access(1'b1, 2'd0, 1'b0, 12'h006, 32'h0000_00A5, 0, 0);
    model_push(1'b0, 2'd1, 1'b1, 12'h002, 32'h0, 0, 0, 1'b1);
    drive_access(1'b0, 2'd1, 1'b1, 12'h002, 32'h0, 0, 0);
    model_push(1'b0, 2'd1, 1'b0, 12'h002, 32'h0, 0, 0, 1'b1);
    drive_access(1'b0, 2'd1, 1'b0, 12'h002, 32'h0, 0, 0);
    model_push(1'b0, 2'd3, 1'b0, 12'h008, 32'h0, 0, 0, 1'b1);
    drive_access(1'b0, 2'd3, 1'b0, 12'h008, 32'h0, 0, 0);
    model_push(1'b1, 2'd2, 1'b0, 12'h00C, 32'hDEAD_BEEF, 1, 0, 1'b1);
    drive_access(1'b1, 2'd2, 1'b0, 12'h00C, 32'hDEAD_BEEF, 1, 0);
    model_push(1'b0, 2'd0, 1'b1, 12'h00F, 32'h0, 0, 1, 1'b1);
    drive_access(1'b0, 2'd0, 1'b1, 12'h00F, 32'h0, 0, 1);
    n_vec++;
    if (obs_addr_q.size() != exp_addr_q.size() || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL aligned count: got beats=%0d rsps=%0d want beats=%0d rsps=%0d",
               obs_addr_q.size(), obs_q.size(), exp_addr_q.size(), exp_q.size());
    end
    while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      oa = obs_addr_q.pop_front(); ow = obs_we_q.pop_front(); od = obs_wd_q.pop_front();
      ea = exp_addr_q.pop_front(); ew = exp_we_q.pop_front(); ed = exp_wd_q.pop_front(); es = exp_st_q.pop_front();
      n_vec++;
      if (oa !== ea || ow !== ew || (es[0] && od !== ed)) begin
        n_err++;
        $display("FAIL aligned beat: got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h", oa, ow, od, ea, ew, ed);
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      orsp = obs_q.pop_front(); ersp = exp_q.pop_front(); ol = obs_lat_q.pop_front(); el = exp_lat_q.pop_front();
      n_vec++;
      if (orsp !== ersp || ol != el) begin
        n_err++;
        $display("FAIL aligned rsp: got err/data=%h cycle=%0d want err/data=%h cycle=%0d", orsp, ol, ersp, el);
      end
    end
    clear_queues();
  endtask

  task automatic test_misaligned_error();
    int lat, el; bit saw; logic [32:0] rsp, ersp; logic st; logic [1:0] sz; logic [11:0] ad;
    for (int t = 0; t < 2; t++) begin
      st = (t == 1); sz = (t == 1) ? 2'd1 : 2'd2; ad = (t == 1) ? 12'h003 : 12'h001;
      model_push(st, sz, 1'b0, ad, 32'h1234_5678, 0, 0, 1'b0);
      for (int n = 0; n < 20 && !req_ready_e; n++) @(negedge clk);
      req_valid_e = 1'b1; req_store = st; req_size = sz; req_signed = 1'b0;
      req_addr = ad; req_wdata = 32'h1234_5678;
      @(posedge clk); @(negedge clk);
      req_valid_e = 1'b0;
      lat = 0; saw = 1'b0; rsp = 'x;
      for (int c = 1; c <= 6; c++) begin
        if (mem_req_e) saw = 1'b1;
        if (rsp_valid_e && lat == 0) begin
          lat = c; rsp = {rsp_err_e, rsp_rdata_e};
        end
        @(posedge clk); @(negedge clk);
      end
      ersp = exp_q.pop_front(); el = exp_lat_q.pop_front();
      n_vec++;
      if (rsp !== ersp || lat != el) begin
        n_err++;
        $display("FAIL misaligned rsp: got err/data=%h cycle=%0d want err/data=%h cycle=%0d", rsp, lat, ersp, el);
      end
      n_vec++;
      if (saw !== 1'b0) begin
        n_err++;
        $display("FAIL misaligned mem_req: got asserted=%b want 0", saw);
      end
    end
    clear_queues();
  endtask

  task automatic test_split();
    logic [9:0] oa, ea; logic [3:0] ow, ew; logic [31:0] od, ed; logic [0:0] es;
    logic [32:0] orsp, ersp; int ol, el;
    phys_mem[0] = 32'h1122_3344; ref_mem[0] = 32'h1122_3344;
    phys_mem[1] = 32'h5566_7788; ref_mem[1] = 32'h5566_7788;
    model_push(1'b0, 2'd2, 1'b0, 12'h003, 32'h0, 0, 0, 1'b1);
    drive_access(1'b0, 2'd2, 1'b0, 12'h003, 32'h0, 0, 0);
    model_push(1'b1, 2'd2, 1'b0, 12'hFFE, 32'hCAFE_F00D, 0, 0, 1'b1);
    drive_access(1'b1, 2'd2, 1'b0, 12'hFFE, 32'hCAFE_F00D, 0, 0);
    model_push(1'b0, 2'd2, 1'b0, 12'hFFE, 32'h0, 1, 2, 1'b1);
    drive_access(1'b0, 2'd2, 1'b0, 12'hFFE, 32'h0, 1, 2);
    model_push(1'b0, 2'd1, 1'b1, 12'h013, 32'h0, 0, 0, 1'b1);
    drive_access(1'b0, 2'd1, 1'b1, 12'h013, 32'h0, 0, 0);
    n_vec++;
    if (obs_addr_q.size() != exp_addr_q.size() || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL split count: got beats=%0d rsps=%0d want beats=%0d rsps=%0d",
               obs_addr_q.size(), obs_q.size(), exp_addr_q.size(), exp_q.size());
    end
    while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      oa = obs_addr_q.pop_front(); ow = obs_we_q.pop_front(); od = obs_wd_q.pop_front();
      ea = exp_addr_q.pop_front(); ew = exp_we_q.pop_front(); ed = exp_wd_q.pop_front(); es = exp_st_q.pop_front();
      n_vec++;
      if (oa !== ea || ow !== ew || (es[0] && od !== ed)) begin
        n_err++;
        $display("FAIL split beat: got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h", oa, ow, od, ea, ew, ed);
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      orsp = obs_q.pop_front(); ersp = exp_q.pop_front(); ol = obs_lat_q.pop_front(); el = exp_lat_q.pop_front();
      n_vec++;
      if (orsp !== ersp || ol != el) begin
        n_err++;
        $display("FAIL split rsp: got err/data=%h cycle=%0d want err/data=%h cycle=%0d", orsp, ol, ersp, el);
      end
    end
    clear_queues();
  endtask

  task automatic test_stall_stray();
    logic [9:0] oa, ea; logic [3:0] ow, ew; logic [31:0] od, ed; logic [0:0] es;
    logic [32:0] orsp, ersp; int ol, el;
    for (int c = 0; c < 3; c++) begin
      mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = $urandom;
      @(posedge clk); @(negedge clk);
      n_vec++;
      if ({rsp_valid, req_ready, mem_req} !== 3'b010) begin
        n_err++;
        $display("FAIL stray idle: got valid/ready/req=%b want 010", {rsp_valid, req_ready, mem_req});
      end
    end
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    model_push(1'b1, 2'd2, 1'b0, 12'h040, 32'h0BAD_F00D, 3, 0, 1'b1);
    drive_access(1'b1, 2'd2, 1'b0, 12'h040, 32'h0BAD_F00D, 3, 0);
    model_push(1'b0, 2'd1, 1'b0, 12'h042, 32'h0, 2, 3, 1'b1);
    drive_access(1'b0, 2'd1, 1'b0, 12'h042, 32'h0, 2, 3);
    model_push(1'b1, 2'd1, 1'b0, 12'h047, 32'hFFFF_9876, 3, 0, 1'b1);
    drive_access(1'b1, 2'd1, 1'b0, 12'h047, 32'hFFFF_9876, 3, 0);
    n_vec++;
    if (obs_addr_q.size() != exp_addr_q.size() || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL stall count: got beats=%0d rsps=%0d want beats=%0d rsps=%0d",
               obs_addr_q.size(), obs_q.size(), exp_addr_q.size(), exp_q.size());
    end
    while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      oa = obs_addr_q.pop_front(); ow = obs_we_q.pop_front(); od = obs_wd_q.pop_front();
      ea = exp_addr_q.pop_front(); ew = exp_we_q.pop_front(); ed = exp_wd_q.pop_front(); es = exp_st_q.pop_front();
      n_vec++;
      if (oa !== ea || ow !== ew || (es[0] && od !== ed)) begin
        n_err++;
        $display("FAIL stall beat: got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h", oa, ow, od, ea, ew, ed);
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      orsp = obs_q.pop_front(); ersp = exp_q.pop_front(); ol = obs_lat_q.pop_front(); el = exp_lat_q.pop_front();
      n_vec++;
      if (orsp !== ersp || ol != el) begin
        n_err++;
        $display("FAIL stall rsp: got err/data=%h cycle=%0d want err/data=%h cycle=%0d", orsp, ol, ersp, el);
      end
    end
    clear_queues();
  endtask

  task automatic test_reset_mid_access();
    bit saw;
    for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 12'h010; req_wdata = 32'h0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    n_vec++;
    if (mem_req !== 1'b1) begin
      n_err++;
      $display("FAIL rst_issue_pre: got mem_req=%b want 1", mem_req);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({mem_req, req_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL rst_issue: got mem_req/req_ready=%b want 01", {mem_req, req_ready});
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_gnt = 1'b0;
    n_vec++;
    if ({mem_req, req_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_wait_pre: got mem_req/req_ready=%b want 00", {mem_req, req_ready});
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({mem_req, req_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL rst_wait: got mem_req/req_ready=%b want 01", {mem_req, req_ready});
    end
    @(negedge clk); reset_n = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom;
      @(posedge clk); @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    mem_rvalid = 1'b0;
    n_vec++;
    if (saw !== 1'b0) begin
      n_err++;
      $display("FAIL rst_no_rsp: got rsp_valid seen=%b want 0", saw);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] oa, ea; logic [3:0] ow, ew; logic [31:0] od, ed; logic [0:0] es;
    logic [32:0] orsp, ersp; int ol, el;
    logic st, sg; logic [1:0] sz; logic [11:0] ad; logic [31:0] wd; int gw, rw;
    for (int i = 0; i < 30; i++) begin
      st = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = 12'($urandom_range(0, 4095)); wd = $urandom;
      gw = $urandom_range(0, 2); rw = $urandom_range(0, 2);
      model_push(st, sz, sg, ad, wd, gw, rw, 1'b1);
      drive_access(st, sz, sg, ad, wd, gw, rw);
    end
    n_vec++;
    if (obs_addr_q.size() != exp_addr_q.size() || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL b2b count: got beats=%0d rsps=%0d want beats=%0d rsps=%0d",
               obs_addr_q.size(), obs_q.size(), exp_addr_q.size(), exp_q.size());
    end
    while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      oa = obs_addr_q.pop_front(); ow = obs_we_q.pop_front(); od = obs_wd_q.pop_front();
      ea = exp_addr_q.pop_front(); ew = exp_we_q.pop_front(); ed = exp_wd_q.pop_front(); es = exp_st_q.pop_front();
      n_vec++;
      if (oa !== ea || ow !== ew || (es[0] && od !== ed)) begin
        n_err++;
        $display("FAIL b2b beat: got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h", oa, ow, od, ea, ew, ed);
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      orsp = obs_q.pop_front(); ersp = exp_q.pop_front(); ol = obs_lat_q.pop_front(); el = exp_lat_q.pop_front();
      n_vec++;
      if (orsp !== ersp || ol != el) begin
        n_err++;
        $display("FAIL b2b rsp: got err/data=%h cycle=%0d want err/data=%h cycle=%0d", orsp, ol, ersp, el);
      end
    end
    clear_queues();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_valid_e = 1'b0; req_store = 1'b0;
    req_size = 2'd0; req_signed = 1'b0; req_addr = 12'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      phys_mem[i] = $urandom;
      ref_mem[i]  = phys_mem[i];
    end
    @(negedge clk);
    test_reset();
    test_aligned();
    test_misaligned_error();
    test_split();
    test_stall_stray();
    test_reset_mid_access();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
